// File: rtl/subbytes_sched_pkg.sv
// Shared types and widths for the SubBytes/SubWord S-box scheduler.
package subbytes_sched_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int STATE_BYTES = AES_STATE_W / 8;
    localparam int WORD_BYTES  = AES_WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_ST = 2'd1,
        RUN_KW = 2'd2
    } state_e;

    typedef enum logic {
        REQ_ST = 1'b0,
        REQ_KW = 1'b1
    } req_e;
endpackage

// File: rtl/subbytes_sched_if.sv
// Request/result bundle between the round/key-schedule control and the S-box scheduler.
interface subbytes_sched_if;
    import subbytes_sched_pkg::*;

    logic                   st_req_valid;
    logic                   st_req_ready;
    logic [AES_STATE_W-1:0] st_in;
    logic                   st_out_valid;
    logic [AES_STATE_W-1:0] st_out;
    logic                   kw_req_valid;
    logic                   kw_req_ready;
    logic [AES_WORD_W-1:0]  kw_in;
    logic                   kw_out_valid;
    logic [AES_WORD_W-1:0]  kw_out;
    logic                   busy;

    modport master (
        output st_req_valid, st_in, kw_req_valid, kw_in,
        input  st_req_ready, st_out_valid, st_out,
        input  kw_req_ready, kw_out_valid, kw_out, busy
    );

    modport slave (
        input  st_req_valid, st_in, kw_req_valid, kw_in,
        output st_req_ready, st_out_valid, st_out,
        output kw_req_ready, kw_out_valid, kw_out, busy
    );
endinterface

// File: rtl/subbytes_sched_sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational.
module subbytes_sched_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX_TBL[din];
endmodule

// File: rtl/subbytes_sched.sv
// Round-robin time-sharing of LANES S-boxes between the state datapath (SubBytes)
// and key expansion (SubWord); operands stream through the lanes LANES bytes per beat.
module subbytes_sched
    import subbytes_sched_pkg::*;
#(
    parameter int LANES = 4
) (
    input logic             clk,
    input logic             rst,
    subbytes_sched_if.slave bus
);
    localparam int         ST_BEATS = STATE_BYTES / LANES;
    localparam int         KW_BEATS = WORD_BYTES / LANES;
    localparam logic [3:0] ST_LAST  = 4'(ST_BEATS - 1);
    localparam logic [3:0] KW_LAST  = 4'(KW_BEATS - 1);

    state_e                 state_q, state_d;
    logic [3:0]             beat_q, beat_d;
    req_e                   rr_q, rr_d;
    logic                   st_out_valid_q, st_out_valid_d;
    logic                   kw_out_valid_q, kw_out_valid_d;
    logic [AES_STATE_W-1:0] st_out_q, st_out_d;
    logic [AES_WORD_W-1:0]  kw_out_q, kw_out_d;
    logic [7:0]             opnd_q [STATE_BYTES];
    logic [7:0]             opnd_d [STATE_BYTES];
    logic [7:0]             res_q  [STATE_BYTES];
    logic [7:0]             res_d  [STATE_BYTES];
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];
    logic                   grant_st, grant_kw;

    // On a tie the requester not granted last wins; readies stay low while reset is held.
    always_comb begin
        grant_st = !rst && (state_q == IDLE) && bus.st_req_valid &&
                   (!bus.kw_req_valid || (rr_q == REQ_KW));
        grant_kw = !rst && (state_q == IDLE) && bus.kw_req_valid &&
                   (!bus.st_req_valid || (rr_q == REQ_ST));
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = opnd_q[4'(32'(beat_q) * LANES + l)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        subbytes_sched_sbox u_sbox (
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        rr_d           = rr_q;
        st_out_valid_d = 1'b0;
        kw_out_valid_d = 1'b0;
        st_out_d       = st_out_q;
        kw_out_d       = kw_out_q;
        opnd_d         = opnd_q;
        res_d          = res_q;

        if (state_q != IDLE) begin
            for (int l = 0; l < LANES; l++) begin
                res_d[4'(32'(beat_q) * LANES + l)] = lane_out[l];
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_st) begin
                    state_d = RUN_ST;
                    rr_d    = REQ_ST;
                    beat_d  = 4'd0;
                    for (int i = 0; i < STATE_BYTES; i++) opnd_d[i] = bus.st_in[8*i +: 8];
                end else if (grant_kw) begin
                    state_d = RUN_KW;
                    rr_d    = REQ_KW;
                    beat_d  = 4'd0;
                    for (int i = 0; i < WORD_BYTES; i++) opnd_d[i] = bus.kw_in[8*i +: 8];
                end
            end
            RUN_ST: begin
                beat_d = beat_q + 4'd1;
                if (beat_q == ST_LAST) begin
                    state_d        = IDLE;
                    beat_d         = 4'd0;
                    st_out_valid_d = 1'b1;
                    for (int i = 0; i < STATE_BYTES; i++) st_out_d[8*i +: 8] = res_d[i];
                end
            end
            RUN_KW: begin
                beat_d = beat_q + 4'd1;
                if (beat_q == KW_LAST) begin
                    state_d        = IDLE;
                    beat_d         = 4'd0;
                    kw_out_valid_d = 1'b1;
                    for (int i = 0; i < WORD_BYTES; i++) kw_out_d[8*i +: 8] = res_d[i];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible results: cleared by reset, which also abandons any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_q         <= 4'd0;
            rr_q           <= REQ_KW;
            st_out_valid_q <= 1'b0;
            kw_out_valid_q <= 1'b0;
            st_out_q       <= '0;
            kw_out_q       <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            rr_q           <= rr_d;
            st_out_valid_q <= st_out_valid_d;
            kw_out_valid_q <= kw_out_valid_d;
            st_out_q       <= st_out_d;
            kw_out_q       <= kw_out_d;
        end
    end

    // Operand capture and partial result are only read under FSM control, so no reset.
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        res_q  <= res_d;
    end

    assign bus.st_req_ready = grant_st;
    assign bus.kw_req_ready = grant_kw;
    assign bus.st_out_valid = st_out_valid_q;
    assign bus.kw_out_valid = kw_out_valid_q;
    assign bus.st_out       = st_out_q;
    assign bus.kw_out       = kw_out_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_subbytes_sched.sv
// Bench for subbytes_sched: a LANES=4 and a LANES=1 instance against a GF(2^8) S-box model.
module tb_subbytes_sched;
    import subbytes_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    subbytes_sched_if bus ();
    subbytes_sched_if bus1 ();

    subbytes_sched #(.LANES(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    subbytes_sched #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]   ref_tbl [256];
    logic [127:0] last_out;

    // Observation mux selected by the running op (instance, requester).
    bit sel_l1, sel_kw;
    logic m_ready, m_ovalid, m_other_v, m_busy;
    logic [127:0] m_out, m_other_out;
    always_comb begin
        if (!sel_l1) begin
            m_busy      = bus.busy;
            m_ready     = sel_kw ? bus.kw_req_ready : bus.st_req_ready;
            m_ovalid    = sel_kw ? bus.kw_out_valid : bus.st_out_valid;
            m_out       = sel_kw ? {96'h0, bus.kw_out} : bus.st_out;
            m_other_v   = sel_kw ? bus.st_out_valid : bus.kw_out_valid;
            m_other_out = sel_kw ? bus.st_out : {96'h0, bus.kw_out};
        end else begin
            m_busy      = bus1.busy;
            m_ready     = sel_kw ? bus1.kw_req_ready : bus1.st_req_ready;
            m_ovalid    = sel_kw ? bus1.kw_out_valid : bus1.st_out_valid;
            m_out       = sel_kw ? {96'h0, bus1.kw_out} : bus1.st_out;
            m_other_v   = sel_kw ? bus1.st_out_valid : bus1.kw_out_valid;
            m_other_out = sel_kw ? bus1.st_out : {96'h0, bus1.kw_out};
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    task automatic build_ref();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
            ref_tbl[x] = s;
        end
    endtask

    function automatic logic [127:0] sub128(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tbl[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_tbl[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        bus.st_req_valid = 1'b0; bus.kw_req_valid = 1'b0; bus.st_in = '0; bus.kw_in = '0;
        bus1.st_req_valid = 1'b0; bus1.kw_req_valid = 1'b0; bus1.st_in = '0; bus1.kw_in = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive(input bit l1, input bit is_kw, input logic v, input logic [127:0] d);
        if (!l1) begin
            if (is_kw) begin bus.kw_req_valid = v; bus.kw_in = d[31:0]; end
            else begin bus.st_req_valid = v; bus.st_in = d; end
        end else begin
            if (is_kw) begin bus1.kw_req_valid = v; bus1.kw_in = d[31:0]; end
            else begin bus1.st_req_valid = v; bus1.st_in = d; end
        end
    endtask

    // One isolated request from IDLE; checks grant, busy, latency, data, pulse and hold.
    task automatic run_op(input bit l1, input bit is_kw, input logic [127:0] d,
                          input int beats, input string nm);
        logic [127:0] exp, other_before;
        int cyc;
        sel_l1 = l1; sel_kw = is_kw;
        exp = is_kw ? {96'h0, sub32(d[31:0])} : sub128(d);
        drive(l1, is_kw, 1'b1, d);
        #1;
        other_before = m_other_out;
        n_tests++;
        if (m_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready: got %b want 1", nm, m_ready);
        end
        @(posedge clk); #1;
        drive(l1, is_kw, 1'b0, rnd128());
        n_tests++;
        if (m_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy: got %b want 1", nm, m_busy);
        end
        cyc = 0;
        while (m_ovalid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== beats) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, beats);
        end
        n_tests++;
        if (m_out !== exp) begin
            n_fail++; $display("FAIL %s data: got %h want %h", nm, m_out, exp);
        end
        n_tests++;
        if (m_other_out !== other_before || m_other_v !== 1'b0) begin
            n_fail++; $display("FAIL %s other requester: got %h/%b want %h/0", nm, m_other_out,
                               m_other_v, other_before);
        end
        last_out = m_out;
        @(posedge clk); #1;
        n_tests++;
        if (m_ovalid !== 1'b0 || m_out !== exp || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s pulse/hold: got v=%b busy=%b out=%h want v=0 busy=0 out=%h",
                               nm, m_ovalid, m_busy, m_out, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.st_req_valid = 1'b1; bus.kw_req_valid = 1'b1; bus.st_in = rnd128(); bus.kw_in = $urandom();
        bus1.st_req_valid = 1'b1; bus1.kw_req_valid = 1'b1; bus1.st_in = rnd128(); bus1.kw_in = $urandom();
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.st_req_ready, bus.kw_req_ready, bus.st_out_valid, bus.kw_out_valid, bus.busy,
             bus.st_out, bus.kw_out} !== '0) begin
            n_fail++; $display("FAIL reset_l4: got st_out=%h kw_out=%h rdy=%b%b want all 0",
                               bus.st_out, bus.kw_out, bus.st_req_ready, bus.kw_req_ready);
        end
        n_tests++;
        if ({bus1.st_req_ready, bus1.kw_req_ready, bus1.st_out_valid, bus1.kw_out_valid, bus1.busy,
             bus1.st_out, bus1.kw_out} !== '0) begin
            n_fail++; $display("FAIL reset_l1: got st_out=%h kw_out=%h rdy=%b%b want all 0",
                               bus1.st_out, bus1.kw_out, bus1.st_req_ready, bus1.kw_req_ready);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [127:0] seq;
        for (int i = 0; i < 16; i++) seq[8*i +: 8] = 8'(i);
        run_op(1'b0, 1'b0, '0, 4, "st_zero");
        n_tests++;
        if (last_out !== {16{8'h63}}) begin
            n_fail++; $display("FAIL st_zero_const: got %h want all 63", last_out);
        end
        run_op(1'b0, 1'b0, seq, 4, "st_seq");
        n_tests++;
        if (last_out !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
            n_fail++; $display("FAIL st_seq_const: got %h want 76abd7fe2b670130c56f6bf27b777c63",
                               last_out);
        end
        run_op(1'b0, 1'b1, {96'h0, 32'h53525100}, 1, "kw_vec");
        n_tests++;
        if (last_out[31:0] !== 32'hed00d163) begin
            n_fail++; $display("FAIL kw_vec_const: got %h want ed00d163", last_out[31:0]);
        end
    endtask

    task automatic test_random_ops();
        bit k;
        for (int n = 0; n < 8; n++) begin
            k = 1'($urandom_range(0, 1));
            run_op(1'b0, k, rnd128(), k ? 1 : 4, k ? "rand_kw" : "rand_st");
        end
    endtask

    task automatic test_busy_wait();
        sel_l1 = 1'b0; sel_kw = 1'b0;
        bus.st_req_valid = 1'b1; bus.st_in = rnd128();
        #1;
        @(posedge clk); #1;
        bus.st_req_valid = 1'b0;
        bus.kw_req_valid = 1'b1; bus.kw_in = $urandom();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (bus.kw_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL busy_no_ready: got %b want 0", bus.kw_req_ready);
            end
            @(posedge clk); #1;
        end
        bus.kw_req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.kw_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL dropped_valid: got busy=%b kw_v=%b want 0 0", bus.busy,
                               bus.kw_out_valid);
        end
    endtask

    // Both requesters always valid: grants alternate, each landing on the previous result pulse.
    task automatic test_back_to_back();
        logic [127:0] st_d, exp_st;
        logic [31:0]  kw_d, exp_kw;
        logic [1:0]   got, want;
        int exp_cyc, st_due, kw_due;
        bit exp_kw_next;
        apply_reset();
        st_d = rnd128(); kw_d = $urandom();
        exp_st = '0; exp_kw = '0;
        exp_cyc = 0; exp_kw_next = 1'b0; st_due = -1; kw_due = -1;
        bus.st_req_valid = 1'b1; bus.kw_req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.st_in = st_d; bus.kw_in = kw_d;
            #1;
            n_tests++;
            if (bus.st_out_valid !== 1'(c == st_due) || (c == st_due && bus.st_out !== exp_st)) begin
                n_fail++; $display("FAIL b2b_st_out cyc %0d: got v=%b %h want v=%b %h", c,
                                   bus.st_out_valid, bus.st_out, c == st_due, exp_st);
            end
            n_tests++;
            if (bus.kw_out_valid !== 1'(c == kw_due) || (c == kw_due && bus.kw_out !== exp_kw)) begin
                n_fail++; $display("FAIL b2b_kw_out cyc %0d: got v=%b %h want v=%b %h", c,
                                   bus.kw_out_valid, bus.kw_out, c == kw_due, exp_kw);
            end
            got  = {bus.kw_req_ready, bus.st_req_ready};
            want = (c == exp_cyc) ? (exp_kw_next ? 2'b10 : 2'b01) : 2'b00;
            n_tests++;
            if (got !== want) begin
                n_fail++; $display("FAIL b2b_grant cyc %0d: got kw/st=%b want %b", c, got, want);
            end
            if (c == exp_cyc) begin
                if (exp_kw_next) begin
                    exp_kw = sub32(kw_d); kw_due = c + 2; exp_cyc = kw_due; kw_d = $urandom();
                end else begin
                    exp_st = sub128(st_d); st_due = c + 5; exp_cyc = st_due; st_d = rnd128();
                end
                exp_kw_next = !exp_kw_next;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        bit seen;
        apply_reset();
        run_op(1'b0, 1'b0, rnd128(), 4, "pre_st");
        run_op(1'b0, 1'b1, rnd128(), 1, "pre_kw");
        bus.st_req_valid = 1'b1; bus.st_in = rnd128();
        #1;
        @(posedge clk); #1;
        bus.st_req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.st_req_ready, bus.kw_req_ready, bus.st_out_valid, bus.kw_out_valid, bus.busy,
             bus.st_out, bus.kw_out} !== '0) begin
            n_fail++; $display("FAIL midop_reset: got st_out=%h kw_out=%h busy=%b want all 0",
                               bus.st_out, bus.kw_out, bus.busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.st_out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL aborted_op_activity: got %b want 0", seen);
        end
        run_op(1'b0, 1'b1, {96'h0, 32'h53525100}, 1, "post_reset_kw");
        n_tests++;
        if (last_out[31:0] !== 32'hed00d163) begin
            n_fail++; $display("FAIL post_reset_kw_const: got %h want ed00d163", last_out[31:0]);
        end
    endtask

    task automatic test_lanes1();
        apply_reset();
        run_op(1'b1, 1'b1, {96'h0, 32'hff0153ff}, 4, "l1_kw");
        n_tests++;
        if (last_out[31:0] !== 32'h167ced16) begin
            n_fail++; $display("FAIL l1_kw_const: got %h want 167ced16", last_out[31:0]);
        end
        run_op(1'b1, 1'b0, {16{8'hff}}, 16, "l1_st_ff");
        n_tests++;
        if (last_out !== {16{8'h16}}) begin
            n_fail++; $display("FAIL l1_st_const: got %h want all 16", last_out);
        end
        run_op(1'b1, 1'b0, rnd128(), 16, "l1_st_rand");
        run_op(1'b1, 1'b1, rnd128(), 4, "l1_kw_rand");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        sel_l1 = 1'b0; sel_kw = 1'b0;
        last_out = '0;
        build_ref();
        test_reset();
        test_vectors();
        test_random_ops();
        test_busy_wait();
        test_back_to_back();
        test_reset_midop();
        test_lanes1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
